sfp_sum_tx: RTL and testbench
=============================

# sfp_sum_tx

Transmitter for the inter-core row-sum link of the dual-core softmax (SFP) datapath. Each core's normalization row needs the peer core's partial absolute sum before it can start division. This block accepts tagged 24-bit local row sums from the accumulation stage and buffers them in a small FIFO. It serializes each sum as a framed multi-beat transfer over a narrow valid/ready link to the peer core, whose receiver reassembles the sum and drives the row's peer-sum input.

## Interface
- bw_psum_out, 24, width of one row sum
- lw, 8, link data width per beat
- bw_tag, 4, row-tag width; must be ≤ lw
- depth, 4, FIFO entries; power of two, ≥ 2
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- sum_in  in  bw_psum_out  local row sum to send
- sum_tag  in  bw_tag  row index carried in the frame header
- sum_vld  in  1  push request for {sum_tag, sum_in}
- full  out  1  FIFO holds depth entries
- link_data  out  lw  current beat
- link_first  out  1  marks the header beat
- link_last  out  1  marks the final beat of a frame
- link_vld  out  1  beat valid
- link_rdy  in  1  peer accepts beat
- busy  out  1  FIFO not empty or frame in flight
- ovf_err  out  1  sticky drop indicator

## Operation
- Frame: 1 header beat plus NB = ceil(bw_psum_out/lw) payload beats (4 beats total at defaults).
  - Header beat = tag zero-extended to lw.
  - Payload beat k = sum[k*lw +: lw], LSB beat first; the last beat is zero-padded above bw_psum_out.
- Push: sum_vld && !full writes an entry. sum_vld && full drops the entry and sets ovf_err. This holds even if a pop occurs in the same cycle.
- ovf_err stays set until reset.
- FSM states:
  - IDLE: go to HDR when FIFO is non-empty.
  - HDR: on transfer, go to PAY with beat counter = 0.
  - PAY: on each transfer, increment the counter. On the transfer with counter == NB-1, pop the FIFO, then go to HDR if another entry remains, else IDLE.
- Transfer occurs when link_vld && link_rdy.
- While link_vld && !link_rdy, link_data, link_first and link_last are held stable.
- link_vld never drops mid-frame.
- link_first = (state == HDR). link_last = (state == PAY && counter == NB-1).
- The head entry is read in place. Pushes during a frame never alter the frame in flight.
- Simultaneous push and pop on a non-full FIFO: both occur, and the count is unchanged.

## Timing
- All outputs are registered.
- Reset values:
  - link_vld, link_first, link_last, full, busy, ovf_err = 0.
  - link_data = 0.
  - FSM = IDLE, FIFO empty, counter = 0.
- Latency: a push at cycle t into an empty, idle block gives a header with link_vld = 1 at t+1.
- With link_rdy held high, one frame takes NB+1 consecutive cycles.
- Back-to-back frames have zero bubbles: the next header is presented in the cycle after the last beat's transfer.
- full and busy update the cycle after the push or pop that changes them.
- Reset mid-frame abandons the partial frame and clears the FIFO; link_vld = 0 the next cycle. The peer receiver resynchronizes on link_first.
- The wrap-around of FIFO read and write pointers is mod depth; count is log2(depth)+1 bits.

## Structure
- Package sfp_pkg:
  - SFP_LINK_W
  - SFP_PSUM_OUT_W
  - SFP_NB(bw_psum_out, lw) beat-count function
  - state enum {IDLE, HDR, PAY}
  - header layout constant
- One sub-module, sfp_sync_fifo: a parameterized synchronous FIFO (width bw_tag+bw_psum_out, depth) exposing full, empty, count, and the head entry without a pop.
- The FSM, beat mux and error flag stay in sfp_sum_tx.

## Test plan
- Single frame: push sum 0x123456, tag 0x5, link_rdy = 1 → beats 0x05(first), 0x56, 0x34, 0x12(last) on 4 consecutive cycles starting t+1; busy falls after the last beat.
- Backpressure: same push, link_rdy toggles 1,0,0,1,… → each beat is held stable while rdy = 0, no beat is skipped or duplicated, and link_vld stays high throughout.
- Back-to-back: push tags 1,2,3 on consecutive cycles with rdy = 1 → 12 contiguous beats in tag order, with link_first on cycles 1, 5 and 9.
- Overflow: rdy = 0, push 6 sums → full after 4 pushes, ovf_err = 1 after the 5th push, and only the first 4 frames are sent once rdy = 1.
- Reset mid-frame: assert reset after the 2nd payload beat → next cycle all outputs = 0 and FIFO empty; a new push afterwards produces a clean frame.
- Width rule: bw_psum_out = 20, lw = 8 → 3 payload beats, with the top nibble of the last beat = 0.

Source files
------------

// File: rtl/sfp_pkg.sv
// Shared constants, types and helpers for the SFP inter-core row-sum link.
package sfp_pkg;

  localparam int unsigned SFP_LINK_W      = 8;
  localparam int unsigned SFP_PSUM_OUT_W  = 24;
  localparam int unsigned SFP_TAG_W       = 4;
  localparam int unsigned SFP_FIFO_DEPTH  = 4;

  // Header beat carries the row tag starting at this bit, zero elsewhere.
  localparam int unsigned SFP_HDR_TAG_LSB = 0;

  function automatic int unsigned SFP_NB(input int unsigned bw_psum_out,
                                         input int unsigned lw);
    return (bw_psum_out + lw - 1) / lw;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } sfp_state_e;

endpackage

// File: rtl/sfp_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and in-place head read.
module sfp_sync_fifo #(
  parameter int unsigned width = 28,
  parameter int unsigned depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [width-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic                     peek_next,
  output logic [width-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nx;
  logic [CW-1:0]    count_next;

  // peek_next exposes the entry behind the head so the next header can be
  // formed in the same cycle the current head is popped.
  always_comb begin
    rd_ptr_nx  = rd_ptr + 1'b1;
    head       = mem[peek_next ? rd_ptr_nx : rd_ptr];
    count_next = count + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr_nx;
      end
      count <= count_next;
      full  <= (count_next == CW'(depth));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/sfp_sum_tx.sv
// Row-sum link transmitter: buffers tagged sums and sends each as a
// header beat followed by LSB-first payload beats over a valid/ready link.
module sfp_sum_tx
  import sfp_pkg::*;
#(
  parameter int unsigned bw_psum_out = SFP_PSUM_OUT_W,
  parameter int unsigned lw          = SFP_LINK_W,
  parameter int unsigned bw_tag      = SFP_TAG_W,
  parameter int unsigned depth       = SFP_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw_psum_out-1:0] sum_in,
  input  logic [bw_tag-1:0]      sum_tag,
  input  logic                   sum_vld,
  output logic                   full,
  output logic [lw-1:0]          link_data,
  output logic                   link_first,
  output logic                   link_last,
  output logic                   link_vld,
  input  logic                   link_rdy,
  output logic                   busy,
  output logic                   ovf_err
);

  localparam int unsigned NB  = SFP_NB(bw_psum_out, lw);
  localparam int unsigned CW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned EW  = bw_tag + bw_psum_out;
  localparam int unsigned FCW = $clog2(depth) + 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  sfp_state_e           state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_inc;
  logic [EW-1:0]        head;
  logic [bw_tag-1:0]    head_tag;
  logic [bw_psum_out-1:0] head_sum;
  logic [bw_tag-1:0]    hdr_tag;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FCW-1:0]       fifo_count;
  logic                 push;
  logic                 pop;
  logic                 queued;
  logic                 remain;

  function automatic logic [lw-1:0] hdr_word(input logic [bw_tag-1:0] t);
    logic [lw-1:0] w;
    w = '0;
    w[SFP_HDR_TAG_LSB +: bw_tag] = t;
    return w;
  endfunction

  function automatic logic [lw-1:0] beat_word(input logic [bw_psum_out-1:0] s,
                                              input logic [CW-1:0]          k);
    logic [NB*lw-1:0] p;
    p = '0;
    p[bw_psum_out-1:0] = s;
    return p[k*lw +: lw];
  endfunction

  sfp_sync_fifo #(
    .width(EW),
    .depth(depth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (push),
    .wr_data   ({sum_tag, sum_in}),
    .rd_en     (pop),
    .peek_next (link_last),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // On the last beat the FIFO is peeking one entry ahead; if nothing is
  // queued behind the frame, a same-cycle push supplies the next header.
  always_comb begin
    push     = sum_vld && !fifo_full;
    pop      = link_vld && link_rdy && link_last;
    head_tag = head[bw_psum_out +: bw_tag];
    head_sum = head[bw_psum_out-1:0];
    queued   = link_last ? (fifo_count > FCW'(1)) : (fifo_count != '0);
    remain   = (fifo_count > FCW'(1)) || push;
    hdr_tag  = queued ? head_tag : sum_tag;
    cnt_inc  = cnt + 1'b1;
  end

  assign full = fifo_full;
  assign busy = !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      link_vld   <= 1'b0;
      link_first <= 1'b0;
      link_last  <= 1'b0;
      link_data  <= '0;
      ovf_err    <= 1'b0;
    end else begin
      if (sum_vld && fifo_full) begin
        ovf_err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (queued || push) begin
            state      <= HDR;
            link_vld   <= 1'b1;
            link_first <= 1'b1;
            link_last  <= 1'b0;
            link_data  <= hdr_word(hdr_tag);
          end
        end
        HDR: begin
          if (link_rdy) begin
            state      <= PAY;
            cnt        <= '0;
            link_first <= 1'b0;
            link_last  <= (LAST == '0);
            link_data  <= beat_word(head_sum, '0);
          end
        end
        PAY: begin
          if (link_rdy) begin
            if (cnt == LAST) begin
              cnt       <= '0;
              link_last <= 1'b0;
              if (remain) begin
                state      <= HDR;
                link_first <= 1'b1;
                link_data  <= hdr_word(hdr_tag);
              end else begin
                state     <= IDLE;
                link_vld  <= 1'b0;
                link_data <= '0;
              end
            end else begin
              cnt       <= cnt_inc;
              link_last <= (cnt_inc == LAST);
              link_data <= beat_word(head_sum, cnt_inc);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_sum_tx.sv
// Directed bench for sfp_sum_tx at default widths plus a 20-bit sum instance.
module tb_sfp_sum_tx;

  logic        clk;
  logic        reset;
  logic [23:0] sum_in;
  logic [3:0]  sum_tag;
  logic        sum_vld;
  logic        full;
  logic [7:0]  link_data;
  logic        link_first;
  logic        link_last;
  logic        link_vld;
  logic        link_rdy;
  logic        busy;
  logic        ovf_err;

  logic [19:0] sum_in20;
  logic [3:0]  sum_tag20;
  logic        sum_vld20;
  logic        full20;
  logic [7:0]  link_data20;
  logic        link_first20;
  logic        link_last20;
  logic        link_vld20;
  logic        link_rdy20;
  logic        busy20;
  logic        ovf_err20;

  int n_checks;
  int n_errors;

  sfp_sum_tx dut (
    .clk        (clk),
    .reset      (reset),
    .sum_in     (sum_in),
    .sum_tag    (sum_tag),
    .sum_vld    (sum_vld),
    .full       (full),
    .link_data  (link_data),
    .link_first (link_first),
    .link_last  (link_last),
    .link_vld   (link_vld),
    .link_rdy   (link_rdy),
    .busy       (busy),
    .ovf_err    (ovf_err)
  );

  sfp_sum_tx #(
    .bw_psum_out(20),
    .lw         (8),
    .bw_tag     (4),
    .depth      (4)
  ) dut20 (
    .clk        (clk),
    .reset      (reset),
    .sum_in     (sum_in20),
    .sum_tag    (sum_tag20),
    .sum_vld    (sum_vld20),
    .full       (full20),
    .link_data  (link_data20),
    .link_first (link_first20),
    .link_last  (link_last20),
    .link_vld   (link_vld20),
    .link_rdy   (link_rdy20),
    .busy       (busy20),
    .ovf_err    (ovf_err20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [3:0]  tag;
    logic [23:0] sum;
    logic        rdy;
    logic        ev;
    logic        ef;
    logic        el;
    logic [7:0]  ed;
    logic        eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [3:0] t, input logic [23:0] s,
                              input logic r, input logic ev, input logic ef,
                              input logic el, input logic [7:0] ed, input logic eb);
    vec_t x;
    x.vld = v; x.tag = t; x.sum = s; x.rdy = r;
    x.ev = ev; x.ef = ef; x.el = el; x.ed = ed; x.eb = eb;
    return x;
  endfunction

  // {vld, first, last, data, busy, full, ovf}
  function automatic logic [13:0] obs();
    return {link_vld, link_first, link_last, link_data, busy, full, ovf_err};
  endfunction

  function automatic logic [10:0] obs20();
    return {link_vld20, link_first20, link_last20, link_data20};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [23:0] ovf_sum(input logic [3:0] i);
    return {4'hC, i, 4'hB, i, 4'hA, i};
  endfunction

  initial begin
    logic [9:0]  exp_beats[$];
    logic [13:0] exp_rst[5];
    logic [10:0] exp20[5];
    int          idx;

    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    sum_in    = '0;
    sum_tag   = '0;
    sum_vld   = 1'b0;
    link_rdy  = 1'b0;
    sum_in20  = '0;
    sum_tag20 = '0;
    sum_vld20 = 1'b0;
    link_rdy20 = 1'b1;

    tick();
    tick();
    chk("reset_state", 32'(obs()), 32'h0);
    chk("reset_state20", 32'(obs20()), 32'h0);
    reset = 1'b0;

    // single frame
    tbl.push_back(mk(1, 4'h5, 24'h123456, 1, 1, 1, 0, 8'h05, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 0, 0, 8'h56, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 0, 0, 8'h34, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 0, 1, 8'h12, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 0, 0, 0, 8'h00, 0));
    // backpressure
    tbl.push_back(mk(1, 4'h5, 24'h123456, 1, 1, 1, 0, 8'h05, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      0, 1, 1, 0, 8'h05, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      0, 1, 1, 0, 8'h05, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 0, 0, 8'h56, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      0, 1, 0, 0, 8'h56, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 0, 0, 8'h34, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      0, 1, 0, 0, 8'h34, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 0, 1, 8'h12, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      0, 1, 0, 1, 8'h12, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 0, 0, 0, 8'h00, 0));
    // back-to-back, tags 1..3
    tbl.push_back(mk(1, 4'h1, 24'h010203, 1, 1, 1, 0, 8'h01, 1));
    tbl.push_back(mk(1, 4'h2, 24'h040506, 1, 1, 0, 0, 8'h03, 1));
    tbl.push_back(mk(1, 4'h3, 24'h070809, 1, 1, 0, 0, 8'h02, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 0, 1, 8'h01, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 1, 0, 8'h02, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 0, 0, 8'h06, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 0, 0, 8'h05, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 0, 1, 8'h04, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 1, 0, 8'h03, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 0, 0, 8'h09, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 0, 0, 8'h08, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 1, 0, 1, 8'h07, 1));
    tbl.push_back(mk(0, 4'h0, 24'h0,      1, 0, 0, 0, 8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      sum_vld  = tbl[i].vld;
      sum_tag  = tbl[i].tag;
      sum_in   = tbl[i].sum;
      link_rdy = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d", i), 32'(obs()),
          32'({tbl[i].ev, tbl[i].ef, tbl[i].el, tbl[i].ed, tbl[i].eb, 1'b0, 1'b0}));
    end
    sum_vld = 1'b0;

    // overflow: six pushes into a stalled link, only four survive
    do_reset();
    link_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      sum_vld = 1'b1;
      sum_tag = 4'(i);
      sum_in  = ovf_sum(4'(i));
      tick();
      if (i == 3) chk("ovf_full_after3", 32'(full), 32'h0);
      if (i == 4) chk("ovf_full_after4", 32'(full), 32'h1);
      if (i == 4) chk("ovf_err_after4", 32'(ovf_err), 32'h0);
      if (i == 5) chk("ovf_err_after5", 32'(ovf_err), 32'h1);
    end
    sum_vld = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      logic [3:0] t;
      logic [23:0] s;
      t = 4'(i);
      s = ovf_sum(t);
      exp_beats.push_back({2'b10, 4'h0, t});
      exp_beats.push_back({2'b00, s[7:0]});
      exp_beats.push_back({2'b00, s[15:8]});
      exp_beats.push_back({2'b01, s[23:16]});
    end
    link_rdy = 1'b1;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (link_vld) begin
        if (idx < exp_beats.size())
          chk($sformatf("ovf_beat%0d", idx), 32'({link_first, link_last, link_data}),
              32'(exp_beats[idx]));
        idx++;
      end
      tick();
    end
    chk("ovf_beat_count", 32'(idx), 32'd16);
    chk("ovf_final", 32'({busy, full, ovf_err}), 32'b001);

    // reset mid-frame after the second payload beat
    do_reset();
    link_rdy = 1'b1;
    sum_vld = 1'b1; sum_tag = 4'h5; sum_in = 24'h123456;
    tick();
    sum_vld = 1'b1; sum_tag = 4'h6; sum_in = 24'h654321;
    tick();
    sum_vld = 1'b0;
    tick();
    chk("rst_pre", 32'({link_vld, link_first, link_last, link_data}), 32'({3'b100, 8'h34}));
    reset = 1'b1;
    tick();
    chk("rst_outputs", 32'(obs()), 32'h0);
    reset = 1'b0;
    tick();
    chk("rst_fifo_empty", 32'(obs()), 32'h0);
    exp_rst[0] = {3'b110, 8'h07, 3'b100};
    exp_rst[1] = {3'b100, 8'hEF, 3'b100};
    exp_rst[2] = {3'b100, 8'hCD, 3'b100};
    exp_rst[3] = {3'b101, 8'hAB, 3'b100};
    exp_rst[4] = '0;
    sum_vld = 1'b1; sum_tag = 4'h7; sum_in = 24'hABCDEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      sum_vld = 1'b0;
      chk($sformatf("rst_new%0d", i), 32'(obs()), 32'(exp_rst[i]));
    end

    // 20-bit sum: three payload beats, top nibble of the last one zero
    do_reset();
    exp20[0] = {3'b110, 8'h09};
    exp20[1] = {3'b100, 8'hCD};
    exp20[2] = {3'b100, 8'hAB};
    exp20[3] = {3'b101, 8'h0F};
    exp20[4] = '0;
    sum_vld20 = 1'b1; sum_tag20 = 4'h9; sum_in20 = 20'hFABCD;
    for (int i = 0; i < 5; i++) begin
      tick();
      sum_vld20 = 1'b0;
      chk($sformatf("w20_beat%0d", i), 32'(obs20()), 32'(exp20[i]));
    end
    chk("w20_idle", 32'({busy20, full20, ovf_err20}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
